// File: rtl/audio_seq_pkg.sv
// Shared step-word layout, sequencer state encoding and tempo decode.
// Pure declarations: no latency, no flow control.
package audio_seq_pkg;

    localparam int STEP_W     = 10;
    localparam int REST_BIT   = 9;
    localparam int LEN_LSB    = 6;
    localparam int LEN_W      = 3;
    localparam int NOTE_LSB   = 0;
    localparam int NOTE_W_DEF = 6;
    localparam int BEAT_W     = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_PLAY  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] TEMPO_X1 = 2'd0;
    localparam logic [1:0] TEMPO_X2 = 2'd1;
    localparam logic [1:0] TEMPO_X4 = 2'd2;
    localparam logic [1:0] TEMPO_X8 = 2'd3;

    // Last beat index of a step: a step spans (1 << sel) note_clk periods.
    function automatic logic [BEAT_W-1:0] tempo_limit(input logic [1:0] sel);
        logic [BEAT_W-1:0] lim;
        lim = 3'd7;
        case (sel)
            TEMPO_X1: lim = 3'd0;
            TEMPO_X2: lim = 3'd1;
            TEMPO_X4: lim = 3'd3;
            TEMPO_X8: lim = 3'd7;
            default:  lim = 3'd7;
        endcase
        return lim;
    endfunction

endpackage

// File: rtl/note_clk_div.sv
// Free-running note clock divider: note_clk toggles every CLK_DIV cycles, o_tick
// is high for the one cycle in which note_clk is first seen high; no flow control.
module note_clk_div #(
    parameter int CLK_DIV = 390625
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_note_clk,
    output logic o_tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             w_tc;

    assign w_tc = (r_cnt == CNT_W'(CLK_DIV - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt      <= '0;
            o_note_clk <= 1'b0;
            o_tick     <= 1'b0;
        end else begin
            // Registered alongside note_clk so both rise in the same cycle.
            o_tick <= w_tc & ~o_note_clk;
            if (w_tc) begin
                r_cnt      <= '0;
                o_note_clk <= ~o_note_clk;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// 16-step pattern sequencer for one sq_channel; new step outputs appear 2 cycles
// after the ending tick (address register + RAM read); no backpressure, stop aborts.
module note_sequencer
    import audio_seq_pkg::*;
#(
    parameter int CLK_DIV = 390625,
    parameter int STEPS   = 16,
    parameter int NOTE_W  = NOTE_W_DEF,
    parameter int IDX_W   = $clog2(STEPS)
) (
    input  logic              i_clk50mhz,
    input  logic              i_rst,
    input  logic              i_play,
    input  logic              i_stop,
    input  logic              i_loop_en,
    input  logic [1:0]        i_tempo_sel,
    input  logic              i_sweep_up,
    input  logic              i_sweep_dn,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_wr_addr,
    input  logic [STEP_W-1:0] i_wr_data,
    output logic [NOTE_W-1:0] o_note_in,
    output logic              o_note_clk,
    output logic              o_note_rst,
    output logic [LEN_W-1:0]  o_note_length,
    output logic [IDX_W-1:0]  o_step_idx,
    output logic              o_busy,
    output logic              o_done
);

    logic [STEP_W-1:0] r_mem [STEPS];
    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_addr;
    logic              r_load;
    logic [BEAT_W-1:0] r_beat_cnt;
    logic [NOTE_W-1:0] r_offset;
    logic [NOTE_W-1:0] r_step_note;
    logic              r_rest;
    logic              w_tick;
    logic              w_step_end;
    logic              w_last;
    logic              w_load;
    logic              w_advance;
    logic [STEP_W-1:0] w_rd_word;
    logic [NOTE_W-1:0] w_base_note;

    note_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_note_clk_div (
        .i_clk      (i_clk50mhz),
        .i_rst      (i_rst),
        .o_note_clk (o_note_clk),
        .o_tick     (w_tick)
    );

    // Pattern RAM is deliberately left out of reset so patterns survive it.
    always_ff @(posedge i_clk50mhz) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign w_rd_word  = r_mem[r_addr];
    assign w_last     = (r_addr == IDX_W'(STEPS - 1));
    assign w_step_end = (r_state == ST_PLAY) && w_tick &&
                        (r_beat_cnt >= tempo_limit(i_tempo_sel));

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (i_play) w_state_nxt = ST_START;
            ST_START: w_state_nxt = ST_PLAY;
            ST_PLAY:  if (w_step_end && w_last && !i_loop_en) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (i_stop) begin
            w_state_nxt = ST_IDLE;
        end
    end

    assign w_advance   = w_step_end && (w_state_nxt == ST_PLAY);
    assign w_load      = ((r_state == ST_START) || r_load) && (w_state_nxt == ST_PLAY);
    assign w_base_note = w_load ? w_rd_word[NOTE_LSB +: NOTE_W] : r_step_note;

    always_ff @(posedge i_clk50mhz) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk50mhz) begin
        if (i_rst) begin
            r_addr        <= '0;
            r_load        <= 1'b0;
            r_beat_cnt    <= '0;
            r_offset      <= '0;
            r_step_note   <= '0;
            r_rest        <= 1'b0;
            o_note_in     <= '0;
            o_note_rst    <= 1'b1;
            o_note_length <= '0;
            o_step_idx    <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
        end else begin
            r_load <= w_advance;

            // Power-of-two STEPS makes the +1 wrap to 0 after the last step.
            if (r_state == ST_IDLE) begin
                r_addr <= '0;
            end else if (w_advance) begin
                r_addr <= r_addr + IDX_W'(1);
            end

            if ((r_state != ST_PLAY) || w_step_end) begin
                r_beat_cnt <= '0;
            end else if (w_tick) begin
                r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
            end

            if (w_tick && i_sweep_up && !i_sweep_dn) begin
                r_offset <= r_offset + NOTE_W'(1);
            end else if (w_tick && i_sweep_dn && !i_sweep_up) begin
                r_offset <= r_offset - NOTE_W'(1);
            end

            if (w_load) begin
                r_step_note   <= w_rd_word[NOTE_LSB +: NOTE_W];
                r_rest        <= w_rd_word[REST_BIT];
                o_note_length <= w_rd_word[LEN_LSB +: LEN_W];
                o_step_idx    <= r_addr;
            end

            // Transposed note keeps tracking the offset while a step is held.
            o_note_in  <= w_base_note + r_offset;
            o_note_rst <= (w_state_nxt != ST_PLAY) || w_load || r_rest;
            o_busy     <= (w_state_nxt == ST_START) || (w_state_nxt == ST_PLAY);
            o_done     <= (w_state_nxt == ST_DONE);
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with CLK_DIV=4 (note_clk period 8 cycles).
module tb_note_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       play = 1'b0;
    logic       stop = 1'b0;
    logic       loop_en = 1'b0;
    logic [1:0] tempo_sel = 2'd0;
    logic       sweep_up = 1'b0;
    logic       sweep_dn = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = 4'd0;
    logic [9:0] wr_data = 10'd0;
    logic [5:0] note_in;
    logic       note_clk;
    logic       note_rst;
    logic [2:0] note_length;
    logic [3:0] step_idx;
    logic       busy;
    logic       done;

    int cyc = 0;
    int n_assert = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int p = 0;
    int r = 0;

    note_sequencer #(.CLK_DIV(4)) dut (
        .i_clk50mhz    (clk),
        .i_rst         (rst),
        .i_play        (play),
        .i_stop        (stop),
        .i_loop_en     (loop_en),
        .i_tempo_sel   (tempo_sel),
        .i_sweep_up    (sweep_up),
        .i_sweep_dn    (sweep_dn),
        .i_wr_en       (wr_en),
        .i_wr_addr     (wr_addr),
        .i_wr_data     (wr_data),
        .o_note_in     (note_in),
        .o_note_clk    (note_clk),
        .o_note_rst    (note_rst),
        .o_note_length (note_length),
        .o_step_idx    (step_idx),
        .o_busy        (busy),
        .o_done        (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
        cyc += n;
    endtask

    task automatic goto(input int e);
        if (e > cyc) adv(e - cyc);
    endtask

    // Next edge index on which a note_clk tick starts (cycle count = 4 mod 8).
    task automatic goto_phase4;
        goto(cyc + ((12 - (cyc % 8)) % 8));
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input int a, input logic [9:0] d);
        wr_en   = 1'b1;
        wr_addr = 4'(a);
        wr_data = d;
        adv(1);
        wr_en   = 1'b0;
    endtask

    task automatic play_pulse;
        play = 1'b1;
        adv(1);
        play = 1'b0;
    endtask

    initial begin
        // 1. reset and divider phase
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        chk("rst note_rst", 32'(note_rst), 1);
        chk("rst busy", 32'(busy), 0);
        chk("rst note_in", 32'(note_in), 0);
        chk("rst note_clk", 32'(note_clk), 0);
        chk("rst step_idx", 32'(step_idx), 0);
        chk("rst done", 32'(done), 0);
        goto(3);
        chk("clk low at 3", 32'(note_clk), 0);
        goto(4);
        chk("clk rise at 4", 32'(note_clk), 1);
        goto(8);
        chk("clk fall at 8", 32'(note_clk), 0);

        // 2. one-shot pattern, tempo x1
        for (int i = 0; i < 16; i++) wr(i, 10'(i + 10));
        goto_phase4();
        p = cyc;
        play_pulse();
        for (int k = 0; k < 16; k++) begin
            goto(p + 2 + 8 * k);
            chk($sformatf("t2 idx%0d", k), 32'(step_idx), k);
            chk($sformatf("t2 note%0d", k), 32'(note_in), 10 + k);
            chk($sformatf("t2 rst_hi%0d", k), 32'(note_rst), 1);
            chk($sformatf("t2 busy%0d", k), 32'(busy), 1);
            goto(p + 3 + 8 * k);
            chk($sformatf("t2 rst_lo%0d", k), 32'(note_rst), 0);
            goto(p + 9 + 8 * k);
            chk($sformatf("t2 idx_end%0d", k), 32'(step_idx), k);
        end
        goto(p + 129);
        chk("t2 done", 32'(done), 1);
        chk("t2 done busy", 32'(busy), 0);
        chk("t2 done rst", 32'(note_rst), 1);
        goto(p + 130);
        chk("t2 done_end", 32'(done), 0);
        chk("t2 idle busy", 32'(busy), 0);
        chk("t2 done count", 32'(done_cnt), 1);

        // 3. looping pattern, tempo x4
        loop_en   = 1'b1;
        tempo_sel = 2'd2;
        goto_phase4();
        p = cyc;
        play_pulse();
        goto(p + 2);
        chk("t3 idx0", 32'(step_idx), 0);
        chk("t3 note0", 32'(note_in), 10);
        goto(p + 3);
        chk("t3 rst_lo0", 32'(note_rst), 0);
        goto(p + 33);
        chk("t3 idx0 held", 32'(step_idx), 0);
        goto(p + 34);
        chk("t3 idx1", 32'(step_idx), 1);
        chk("t3 note1", 32'(note_in), 11);
        goto(p + 2 + 32 * 15);
        chk("t3 idx15", 32'(step_idx), 15);
        chk("t3 note15", 32'(note_in), 25);
        goto(p + 2 + 32 * 16);
        chk("t3 wrap idx", 32'(step_idx), 0);
        chk("t3 wrap note", 32'(note_in), 10);
        chk("t3 wrap rst", 32'(note_rst), 1);
        goto(p + 3 + 32 * 16);
        chk("t3 wrap busy", 32'(busy), 1);
        chk("t3 no done", 32'(done_cnt), 1);
        stop = 1'b1;
        adv(1);
        stop = 1'b0;
        chk("t3 stop busy", 32'(busy), 0);

        // 4. rest step
        loop_en   = 1'b0;
        tempo_sel = 2'd0;
        wr(3, 10'h34D);
        goto_phase4();
        p = cyc;
        play_pulse();
        goto(p + 18);
        chk("t4 step2 rst", 32'(note_rst), 1);
        goto(p + 19);
        chk("t4 step2 rst_lo", 32'(note_rst), 0);
        goto(p + 26);
        chk("t4 idx3", 32'(step_idx), 3);
        chk("t4 note3", 32'(note_in), 13);
        chk("t4 len3", 32'(note_length), 5);
        chk("t4 rest a", 32'(note_rst), 1);
        goto(p + 27);
        chk("t4 rest b", 32'(note_rst), 1);
        goto(p + 33);
        chk("t4 rest c", 32'(note_rst), 1);
        goto(p + 34);
        chk("t4 idx4", 32'(step_idx), 4);
        chk("t4 len4", 32'(note_length), 0);
        goto(p + 35);
        chk("t4 step4 rst_lo", 32'(note_rst), 0);
        goto(p + 36);
        stop = 1'b1;
        adv(1);
        stop = 1'b0;
        chk("t4 stop busy", 32'(busy), 0);
        chk("t4 stop rst", 32'(note_rst), 1);

        // 5. transpose wrap and sweep hold
        tempo_sel = 2'd3;
        wr(0, 10'h03F);
        goto_phase4();
        p = cyc;
        play_pulse();
        goto(p + 2);
        chk("t5 note63", 32'(note_in), 63);
        sweep_up = 1'b1;
        goto(p + 9);
        sweep_up = 1'b0;
        chk("t5 pre-wrap", 32'(note_in), 63);
        goto(p + 10);
        chk("t5 wrap to 0", 32'(note_in), 0);
        sweep_up = 1'b1;
        sweep_dn = 1'b1;
        goto(p + 33);
        sweep_up = 1'b0;
        sweep_dn = 1'b0;
        goto(p + 34);
        chk("t5 both hold", 32'(note_in), 0);
        chk("t5 still step0", 32'(step_idx), 0);
        sweep_dn = 1'b1;
        goto(p + 41);
        sweep_dn = 1'b0;
        goto(p + 42);
        chk("t5 sweep down", 32'(note_in), 63);
        stop = 1'b1;
        adv(1);
        stop = 1'b0;
        chk("t5 stop busy", 32'(busy), 0);

        // 6. stop with play held, then rst mid-step
        tempo_sel = 2'd0;
        goto_phase4();
        p = cyc;
        play = 1'b1;
        goto(p + 58);
        chk("t6 idx7", 32'(step_idx), 7);
        chk("t6 note7", 32'(note_in), 17);
        goto(p + 60);
        stop = 1'b1;
        adv(1);
        chk("t6 stop busy", 32'(busy), 0);
        chk("t6 stop rst", 32'(note_rst), 1);
        chk("t6 stop done", 32'(done), 0);
        stop = 1'b0;
        play = 1'b0;
        adv(1);
        chk("t6 stays idle", 32'(busy), 0);
        goto_phase4();
        p = cyc;
        play_pulse();
        goto(p + 18);
        chk("t6 idx2", 32'(step_idx), 2);
        chk("t6 note2", 32'(note_in), 12);
        goto(p + 21);
        rst = 1'b1;
        adv(1);
        rst = 1'b0;
        r = cyc;
        chk("t6 rst note_in", 32'(note_in), 0);
        chk("t6 rst note_clk", 32'(note_clk), 0);
        chk("t6 rst note_rst", 32'(note_rst), 1);
        chk("t6 rst length", 32'(note_length), 0);
        chk("t6 rst idx", 32'(step_idx), 0);
        chk("t6 rst busy", 32'(busy), 0);
        chk("t6 rst done", 32'(done), 0);
        goto(r + 3);
        chk("t6 clk low", 32'(note_clk), 0);
        goto(r + 4);
        chk("t6 clk rise", 32'(note_clk), 1);
        chk("t6 idle busy", 32'(busy), 0);
        chk("final done count", 32'(done_cnt), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
